mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Memory-access stage of pipelined_core, directly downstream of the EX ALU.
//   Consumes the EX result (address/ALU value, store data, rd, controls), performs
//   LB/LH/LW/LBU/LHU/SB/SH/SW over a req/gnt/rvalid data-memory bus, and presents
//   a registered result to writeback. Stalls EX via ex_ready while an access is pending.
// PARAMETERS
//   XLEN      32  datapath width (only 32 supported)
//   REG_AW    5   register-index width
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, ACTIVE-LOW reset (reset==0 resets on clk edge)
//   ex_valid      in   1      EX presents an instruction this cycle
//   ex_ready      out  1      stage accepts EX instruction (transfer = ex_valid & ex_ready)
//   ex_alu_out    in   32     effective address, or ALU result for non-memory ops
//   ex_rs2        in   32     store data
//   ex_rd         in   5      destination register
//   ex_reg_write  in   1      instruction writes rd
//   ex_mem_read   in   1      load
//   ex_mem_write  in   1      store
//   ex_funct3     in   3      RV32I access size/sign
//   dmem_req      out  1      bus request, held until dmem_gnt
//   dmem_we       out  1      1=store
//   dmem_addr     out  32     word-aligned address ({addr[31:2],2'b00})
//   dmem_wdata    out  32     lane-replicated store data
//   dmem_wstrb    out  4      byte enables (0 for loads)
//   dmem_gnt      in   1      request accepted this cycle
//   dmem_rvalid   in   1      load data valid
//   dmem_rdata    in   32     load data word
//   wb_valid      out  1      one-cycle result pulse to writeback
//   wb_rd         out  5      destination
//   wb_reg_write  out  1      write enable (0 if rd==0 or fault)
//   wb_data       out  32     ALU value or extended load value
//   wb_fault      out  1      misaligned/illegal access
// BEHAVIOUR
//   Reset: state=IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, wb_fault=0;
//     dmem_addr, dmem_wdata, wb_data=0; dmem_wstrb=0; wb_rd=0.
//   FSM: IDLE -> REQ on accepted load/store with no fault; REQ -> IDLE on gnt (store),
//     REQ -> WAIT_R on gnt (load); WAIT_R -> IDLE on rvalid. ex_ready = (state==IDLE).
//   Non-memory op accepted at edge N: wb_valid=1 in cycle N+1, wb_data=ex_alu_out.
//   Store accepted at N: dmem_req=1 from N+1 until gnt seen in cycle G; wb_valid at G+1.
//   Load: gnt in cycle G, rvalid in cycle R (R>G; rvalid in the gnt cycle is ignored);
//     wb_valid at R+1. Minimum load latency 3 cycles, store 2, ALU 1.
//   Exactly one outstanding access; bus outputs stable while dmem_req & !dmem_gnt.
//   Size: funct3 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
//   Fault (wb_valid next cycle, wb_fault=1, wb_reg_write=0, no bus request) when:
//     H/HU with addr[0]=1; W with addr[1:0]!=0; undefined funct3; mem_read&mem_write.
//   Store lanes: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0];
//     SH wdata={2{rs2[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011; SW wstrb=4'b1111.
//   Load: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
//   wb_reg_write = ex_reg_write & (rd!=0) & !fault; stores never write rd.
//   wb_valid is a single-cycle pulse; 0 in all other cycles.
//   Reset mid-access: FSM to IDLE immediately, dmem_req dropped, any later stray
//     rvalid/gnt in IDLE is ignored; no wb_valid produced for the aborted access.
// STRUCTURE
//   Package rv_mem_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), state enum
//     {IDLE,REQ,WAIT_R}, wstrb helper function.
//   Sub-module load_align: combinational lane select + sign/zero extension
//     (rdata, addr[1:0], funct3 -> 32-bit result). All else in mem_stage.
// TESTING
//   ALU op rd=5, alu_out=0x1234 -> wb_valid 1 cycle later, wb_data=0x1234, wb_reg_write=1.
//   SB addr=0x103, rs2=0xAB, gnt after 2 waits -> wdata=0xABABABAB, wstrb=1000, addr=0x100.
//   LB addr=0x102, rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080.
//   LW addr=0x102 -> wb_fault=1, wb_reg_write=0, dmem_req never asserted.
//   Load with rvalid delayed 4 cycles -> ex_ready=0 throughout; next ALU op waits, then 1-cycle.
//   reset=0 while in WAIT_R, then rvalid -> no wb_valid; dmem_req=0; state IDLE.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states,
// and helpers that build store lanes and detect illegal accesses.
package rv_mem_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << lo;
            F3_H:    strb = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] data;
        case (f3)
            F3_B:    data = {4{rs2[7:0]}};
            F3_H:    data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

    // Loads and stores share alignment rules; unsigned sizes are loads only.
    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic f;
        f = 1'b0;
        if (rd && wr) begin
            f = 1'b1;
        end else if (rd) begin
            case (f3)
                F3_B, F3_BU: f = 1'b0;
                F3_H, F3_HU: f = lo[0];
                F3_W:        f = (lo != 2'b00);
                default:     f = 1'b1;
            endcase
        end else if (wr) begin
            case (f3)
                F3_B:    f = 1'b0;
                F3_H:    f = lo[0];
                F3_W:    f = (lo != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a returned load word and extends it
// according to the access size and signedness.
module load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by sign/zero extension
    always_comb begin
        byte_s   = 8'h00;
        half_s   = 16'h0000;
        result_o = 32'h0000_0000;
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   result_o = {24'h00_0000, byte_s};
            F3_H:    result_o = {{16{half_s[15]}}, half_s};
            F3_HU:   result_o = {16'h0000, half_s};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access at a time over req/gnt/rvalid,
// stalls EX while busy, and emits a one-cycle registered writeback result.
module mem_stage
    import rv_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_fault
);

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic                wb_rw_q, wb_rw_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                wb_fault_q, wb_fault_d;
    logic [1:0]          pend_lo_q, pend_lo_d;
    logic [2:0]          pend_f3_q, pend_f3_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                pend_rw_q, pend_rw_d;
    logic                is_mem_s;
    logic                fault_s;
    logic                rd_nz_s;
    logic [XLEN-1:0]     load_s;

    load_align u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (pend_lo_q),
        .funct3_i  (pend_f3_q),
        .result_o  (load_s)
    );

    assign ex_ready = (state_q == IDLE);

    // Next-state and next-output logic; wb_valid defaults low so it only pulses
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        wb_fault_d = wb_fault_q;
        pend_lo_d  = pend_lo_q;
        pend_f3_d  = pend_f3_q;
        pend_rd_d  = pend_rd_q;
        pend_rw_d  = pend_rw_q;
        is_mem_s   = ex_mem_read | ex_mem_write;
        rd_nz_s    = (ex_rd != {REG_AW{1'b0}});
        if (is_mem_s) begin
            fault_s = access_fault(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_out[1:0]);
        end else begin
            fault_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ex_valid && is_mem_s && !fault_s) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    we_d      = ex_mem_write;
                    addr_d    = {ex_alu_out[XLEN-1:2], 2'b00};
                    wdata_d   = ex_mem_write ? store_wdata(ex_funct3, ex_rs2) : 32'h0000_0000;
                    wstrb_d   = ex_mem_write ? store_wstrb(ex_funct3, ex_alu_out[1:0]) : 4'b0000;
                    pend_lo_d = ex_alu_out[1:0];
                    pend_f3_d = ex_funct3;
                    pend_rd_d = ex_rd;
                    pend_rw_d = ex_reg_write & rd_nz_s & ~ex_mem_write;
                end else if (ex_valid) begin
                    // ALU results and faulting accesses retire without touching the bus
                    wb_valid_d = 1'b1;
                    wb_rd_d    = ex_rd;
                    wb_rw_d    = ex_reg_write & rd_nz_s & ~fault_s;
                    wb_data_d  = ex_alu_out;
                    wb_fault_d = fault_s;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt && we_q) begin
                    req_d      = 1'b0;
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = pend_rd_q;
                    wb_rw_d    = 1'b0;
                    wb_data_d  = 32'h0000_0000;
                    wb_fault_d = 1'b0;
                end else if (dmem_gnt) begin
                    req_d   = 1'b0;
                    state_d = WAIT_R;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = pend_rd_q;
                    wb_rw_d    = pend_rw_q;
                    wb_data_d  = load_s;
                    wb_fault_d = 1'b0;
                end else begin
                    state_d = WAIT_R;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= 32'h0000_0000;
            wb_fault_q <= 1'b0;
            pend_lo_q  <= 2'b00;
            pend_f3_q  <= 3'b000;
            pend_rd_q  <= 5'd0;
            pend_rw_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            wb_fault_q <= wb_fault_d;
            pend_lo_q  <= pend_lo_d;
            pend_f3_q  <= pend_f3_d;
            pend_rd_q  <= pend_rd_d;
            pend_rw_q  <= pend_rw_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign wb_fault     = wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for ALU, store, load,
// fault, stall and mid-access reset behaviour.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        wb_fault;

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        ex_valid = 1'b1; ex_alu_out = alu; ex_rs2 = rs2; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [2:0] f3, input int waits,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
        drive(addr, rs2, 5'd9, 1'b1, 1'b0, 1'b1, f3);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
            chk({tag, "_rdy"}, {31'd0, ex_ready}, 32'd0);
            tick();
        end
        chk({tag, "_we"},    {31'd0, dmem_we}, 32'd1);
        chk({tag, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({tag, "_wbv"},  {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wbrw"}, {31'd0, wb_reg_write}, 32'd0);
        chk({tag, "_reqoff"}, {31'd0, dmem_req}, 32'd0);
        tick();
        chk({tag, "_pulse"}, {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        drive(addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, f3);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
        chk({tag, "_we"},    {31'd0, dmem_we}, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, 32'd0);
        chk({tag, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_gnt = 1'b0; dmem_rdata = rdata;
        chk({tag, "_early"}, {31'd0, wb_valid}, 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        chk({tag, "_wbv"},   {31'd0, wb_valid}, 32'd1);
        chk({tag, "_data"},  wb_data, exp);
        chk({tag, "_rd"},    {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, "_rw"},    {31'd0, wb_reg_write}, 32'd1);
        chk({tag, "_flt"},   {31'd0, wb_fault}, 32'd0);
        tick();
    endtask

    task automatic do_fault(input string tag, input logic [31:0] addr, input logic mr,
                            input logic mw, input logic [2:0] f3);
        drive(addr, 32'h1111_2222, 5'd4, 1'b1, mr, mw, f3);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_flt"}, {31'd0, wb_fault}, 32'd1);
        chk({tag, "_rw"},  {31'd0, wb_reg_write}, 32'd0);
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        tick();
        chk({tag, "_req2"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_rdy"},  {31'd0, ex_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; ex_alu_out = 32'h0; ex_rs2 = 32'h0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("rst_wbv",   {31'd0, wb_valid}, 32'd0);
        chk("rst_data",  wb_data, 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        chk("rst_rd",    {27'd0, wb_rd}, 32'd0);
        reset = 1'b1;
        tick();

        // ALU op
        drive(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        ex_valid = 1'b0;
        chk("alu_wbv",  {31'd0, wb_valid}, 32'd1);
        chk("alu_data", wb_data, 32'h0000_1234);
        chk("alu_rw",   {31'd0, wb_reg_write}, 32'd1);
        chk("alu_rd",   {27'd0, wb_rd}, 32'd5);
        tick();
        chk("alu_pulse", {31'd0, wb_valid}, 32'd0);

        // ALU op to x0 never writes
        drive(32'h0000_0077, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        ex_valid = 1'b0;
        chk("x0_wbv", {31'd0, wb_valid}, 32'd1);
        chk("x0_rw",  {31'd0, wb_reg_write}, 32'd0);
        tick();

        do_store("sb", 32'h0000_0103, 32'h0000_00AB, 3'b000, 2, 32'hABAB_ABAB, 4'b1000);
        do_store("sh", 32'h0000_0102, 32'h1234_CDEF, 3'b001, 0, 32'hCDEF_CDEF, 4'b1100);
        do_store("sw", 32'h0000_0200, 32'hCAFE_F00D, 3'b010, 1, 32'hCAFE_F00D, 4'b1111);

        do_load("lb",  32'h0000_0102, 3'b000, 5'd7, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_0102, 3'b100, 5'd7, 32'h0080_0000, 32'h0000_0080);
        do_load("lhu", 32'h0000_0104, 3'b101, 5'd8, 32'h1234_F00F, 32'h0000_F00F);
        do_load("lw",  32'h0000_0100, 3'b010, 5'd9, 32'h1234_5678, 32'h1234_5678);

        do_fault("lw_mis", 32'h0000_0102, 1'b1, 1'b0, 3'b010);
        do_fault("lh_mis", 32'h0000_0101, 1'b1, 1'b0, 3'b001);
        do_fault("f3_bad", 32'h0000_0100, 1'b1, 1'b0, 3'b011);
        do_fault("sbu",    32'h0000_0100, 1'b0, 1'b1, 3'b100);
        do_fault("rd_wr",  32'h0000_0100, 1'b1, 1'b1, 3'b000);

        // LH with rvalid delayed 4 cycles while an ALU op waits in EX
        drive(32'h0000_0106, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b001);
        tick();
        drive(32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b010);
        chk("dly_rdy_req", {31'd0, ex_ready}, 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dly_rdy", {31'd0, ex_ready}, 32'd0);
            chk("dly_wbv", {31'd0, wb_valid}, 32'd0);
            tick();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
        tick();
        dmem_rvalid = 1'b0;
        chk("dly_wbv1",  {31'd0, wb_valid}, 32'd1);
        chk("dly_data",  wb_data, 32'hFFFF_8001);
        chk("dly_rd",    {27'd0, wb_rd}, 32'd10);
        chk("dly_rdy1",  {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0;
        chk("dly_alu_v", {31'd0, wb_valid}, 32'd1);
        chk("dly_alu_d", wb_data, 32'h0000_0055);
        chk("dly_alu_r", {27'd0, wb_rd}, 32'd3);
        tick();
        chk("dly_pulse", {31'd0, wb_valid}, 32'd0);

        // Reset while waiting for load data
        drive(32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        reset = 1'b0;
        tick();
        chk("rmid_req", {31'd0, dmem_req}, 32'd0);
        chk("rmid_rdy", {31'd0, ex_ready}, 32'd1);
        chk("rmid_wbv", {31'd0, wb_valid}, 32'd0);
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        chk("rmid_stray_v", {31'd0, wb_valid}, 32'd0);
        chk("rmid_stray_r", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("rmid_after_v", {31'd0, wb_valid}, 32'd0);
        chk("rmid_after_r", {31'd0, ex_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
